// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : shared constants, state encoding and helpers for the TX arbiter
// Rev 1.0
// ============================================================================
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_START     = 2'd1;
  localparam logic [1:0] ST_WAIT_ACK  = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE      = ST_IDLE,
    S_START     = ST_START,
    S_WAIT_ACK  = ST_WAIT_ACK,
    S_WAIT_DONE = ST_WAIT_DONE
  } state_e;

  // Never returns less than 1 so that single-bit selectors stay legal.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// uart_tx_arbiter_if : requester byte streams plus transmitter side signals
// Rev 1.0
// ============================================================================
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
);
  import uart_pkg::*;

  logic [NUM_REQ-1:0]             req_valid;
  logic [UART_BYTE_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]             req_last;
  logic [NUM_REQ-1:0]             req_ready;
  logic                           tx_start;
  logic [UART_BYTE_W-1:0]         tx_data;
  logic                           tx_busy;
  logic                           lock_active;
  logic [IDW-1:0]                 grant_id;
  logic                           pkt_abort;

  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, tx_start, tx_data, lock_active, grant_id, pkt_abort
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_start, tx_data, lock_active, grant_id, pkt_abort
  );

endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// rr_pick : combinational round-robin picker, first request at or above ptr
// Rev 1.0
// ============================================================================
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] grant_o,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  always_comb begin
    int s;
    logic [W-1:0] j;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    s       = 0;
    j       = '0;
    for (int k = 0; k < N; k++) begin
      s = int'(ptr_i) + k;
      if (s >= N) s = s - N;
      j = W'(s);
      if (!any_o && req_i[j]) begin
        any_o      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = j;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// uart_tx_arbiter : packet-locked round-robin sharing of one UART transmitter
// Rev 1.0
// ============================================================================
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 1024
) (
  input logic              clk,
  input logic              rst_n,
  uart_tx_arbiter_if.slave bus
);

  localparam int CNT_W = clog2(TIMEOUT);

  state_e                 state_q;
  logic                   tx_start_q;
  logic                   lock_q;
  logic                   abort_q;
  logic [UART_BYTE_W-1:0] tx_data_q;
  logic [IDW-1:0]         grant_q;
  logic [IDW-1:0]         rr_ptr_q;
  logic [CNT_W-1:0]       cnt_q;

  logic [NUM_REQ-1:0]     pick_grant;
  logic [NUM_REQ-1:0]     owner_mask;
  logic [NUM_REQ-1:0]     ready;
  logic [IDW-1:0]         pick_idx;
  logic [IDW-1:0]         sel_idx;
  logic [IDW-1:0]         rr_ptr_d;
  logic                   pick_any;
  logic                   accept_ok;
  logic                   owner_valid;
  logic                   xfer;
  logic                   sel_last;
  logic [UART_BYTE_W-1:0] sel_byte;

  rr_pick #(.N(NUM_REQ), .W(IDW)) u_pick (
    .req_i   (bus.req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // Accepting while tx_busy is high would restart a transmitter that is still
  // finishing a frame begun before a reset.
  assign accept_ok   = (state_q == S_IDLE) && !bus.tx_busy && rst_n;
  assign owner_valid = bus.req_valid[grant_q];
  assign sel_idx     = lock_q ? grant_q : pick_idx;
  assign xfer        = accept_ok && (lock_q ? owner_valid : pick_any);
  assign rr_ptr_d    = (pick_idx == IDW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;

  always_comb begin
    owner_mask          = '0;
    owner_mask[grant_q] = 1'b1;
    ready               = '0;
    if (accept_ok) ready = lock_q ? (owner_mask & bus.req_valid) : pick_grant;
  end

  always_comb begin
    sel_byte = '0;
    sel_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDW'(i) == sel_idx) begin
        sel_byte = bus.req_data[UART_BYTE_W*i +: UART_BYTE_W];
        sel_last = bus.req_last[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      lock_q     <= 1'b0;
      grant_q    <= '0;
      abort_q    <= 1'b0;
      rr_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      tx_start_q <= 1'b0;
      abort_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (xfer) begin
            tx_data_q  <= sel_byte;
            tx_start_q <= 1'b1;
            cnt_q      <= '0;
            state_q    <= S_START;
            if (lock_q) begin
              if (sel_last) lock_q <= 1'b0;
            end else begin
              grant_q  <= pick_idx;
              rr_ptr_q <= rr_ptr_d;
              lock_q   <= !sel_last;
            end
          end else if (lock_q && !owner_valid) begin
            if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
              lock_q  <= 1'b0;
              abort_q <= 1'b1;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else if (!lock_q) begin
            cnt_q <= '0;
          end
        end
        S_START:     state_q <= S_WAIT_ACK;
        S_WAIT_ACK:  if (bus.tx_busy) state_q <= S_WAIT_DONE;
        S_WAIT_DONE: if (!bus.tx_busy) state_q <= S_IDLE;
        default:     state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready   = ready;
  assign bus.tx_start    = tx_start_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.lock_active = lock_q;
  assign bus.grant_id    = grant_q;
  assign bus.pkt_abort   = abort_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_arbiter : scoreboard bench with a one-cycle-per-bit UART model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(4), .IDW(2)) bus ();

  uart_tx_arbiter #(.NUM_REQ(4), .IDW(2), .TIMEOUT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int start_cnt = 0;
  logic [9:0] exp_q [$];
  logic [7:0] exp_txd [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s: bounded wait expired", nm);
  endtask

  // Transmitter model, one bit per clock; it is never reset by rst_n.
  logic       m_busy = 1'b0;
  logic [9:0] m_sh   = '1;
  int         m_n    = 0;
  wire        txd    = m_busy ? m_sh[0] : 1'b1;
  assign bus.tx_busy = m_busy;

  always @(posedge clk) begin
    if (!m_busy && bus.tx_start) begin
      m_busy <= 1'b1;
      m_sh   <= {1'b1, bus.tx_data, 1'b0};
      m_n    <= 10;
    end else if (m_busy) begin
      m_sh <= {1'b1, m_sh[9:1]};
      m_n  <= m_n - 1;
      if (m_n == 1) m_busy <= 1'b0;
    end
  end

  // Requester lanes: byte FIFOs presented over valid/ready.
  logic [8:0] lane_mem [4][32];
  int lane_wr [4];
  int lane_rd [4];

  task automatic push(input int l, input logic [7:0] d, input logic last);
    lane_mem[l][lane_wr[l]] = {last, d};
    lane_wr[l] = lane_wr[l] + 1;
    exp_q.push_back({2'(l), d});
    exp_txd.push_back(d);
  endtask

  initial begin
    logic [3:0] xf;
    for (int i = 0; i < 4; i++) begin
      lane_wr[i] = 0;
      lane_rd[i] = 0;
    end
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    forever begin
      @(negedge clk);
      xf = bus.req_valid & bus.req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (xf[i]) lane_rd[i] = lane_rd[i] + 1;
        if (lane_rd[i] < lane_wr[i]) begin
          bus.req_valid[i]       = 1'b1;
          bus.req_data[8*i +: 8] = lane_mem[i][lane_rd[i]][7:0];
          bus.req_last[i]        = lane_mem[i][lane_rd[i]][8];
        end else begin
          bus.req_valid[i] = 1'b0;
          bus.req_last[i]  = 1'b0;
        end
      end
    end
  end

  // Scoreboard monitor for start pulses.
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (bus.tx_start === 1'b1) begin
        start_cnt++;
        chk("start_while_busy", {31'b0, m_busy}, 32'd0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_start: tx_data=%0h with nothing pending", bus.tx_data);
        end else begin
          e = exp_q.pop_front();
          chk("tx_data", {24'b0, bus.tx_data}, {24'b0, e[7:0]});
          chk("grant_id", {30'b0, bus.grant_id}, {30'b0, e[9:8]});
        end
      end
    end
  end

  // Serial receiver on the model's TxD line.
  initial begin
    logic [9:0] bits;
    logic [7:0] d;
    int n;
    n    = 0;
    bits = '0;
    forever begin
      @(negedge clk);
      if (m_busy) begin
        bits[n] = txd;
        n++;
        if (n == 10) begin
          n = 0;
          chk("txd_start_bit", {31'b0, bits[0]}, 32'd0);
          chk("txd_stop_bit", {31'b0, bits[9]}, 32'd1);
          if (exp_txd.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_frame: byte=%0h with nothing pending", bits[8:1]);
          end else begin
            d = exp_txd.pop_front();
            chk("txd_byte", {24'b0, bits[8:1]}, {24'b0, d});
          end
        end
      end
    end
  end

  task automatic wait_start(input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.tx_start !== 1'b1 && n < 300);
    if (bus.tx_start !== 1'b1) fail_now(nm);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || exp_txd.size() != 0 || m_busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) fail_now("drain");
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    logic [31:0] lock_exp [6];
    lock_exp = '{1, 1, 0, 1, 1, 0};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_ready", {28'b0, bus.req_ready}, 32'd0);
    chk("rst_tx_start", {31'b0, bus.tx_start}, 32'd0);
    chk("rst_tx_data", {24'b0, bus.tx_data}, 32'd0);
    chk("rst_lock", {31'b0, bus.lock_active}, 32'd0);
    chk("rst_grant", {30'b0, bus.grant_id}, 32'd0);
    chk("rst_abort", {31'b0, bus.pkt_abort}, 32'd0);
    rst_n = 1'b1;

    // 1: single-byte packet from requester 2
    @(posedge clk);
    #2;
    push(2, 8'hA5, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.req_valid[2] !== 1'b1 && n < 10);
    chk("t1_ready", {28'b0, bus.req_ready}, 32'b0100);
    @(negedge clk);
    chk("t1_start_latency", {31'b0, bus.tx_start}, 32'd1);
    chk("t1_lock", {31'b0, bus.lock_active}, 32'd0);
    drain();

    // 2: two 3-byte packets, no interleaving, lock over each packet
    do_reset();
    push(0, 8'h0A, 1'b0); push(0, 8'h0B, 1'b0); push(0, 8'h0C, 1'b1);
    push(3, 8'h3A, 1'b0); push(3, 8'h3B, 1'b0); push(3, 8'h3C, 1'b1);
    for (int k = 0; k < 6; k++) begin
      wait_start("t2_start");
      chk("t2_lock", {31'b0, bus.lock_active}, lock_exp[k]);
    end
    drain();

    // 3: all four valid with single-byte packets, pointer wraps
    do_reset();
    push(0, 8'h10, 1'b1); push(1, 8'h11, 1'b1); push(2, 8'h12, 1'b1);
    push(3, 8'h13, 1'b1); push(0, 8'h20, 1'b1); push(1, 8'h21, 1'b1);
    drain();

    // 4: owner stalls mid-packet; waiting requester 2 takes over after abort
    do_reset();
    push(1, 8'h11, 1'b0);
    push(2, 8'h22, 1'b1);
    wait_start("t4_start");
    // start, 10 busy cycles, one WAIT_DONE exit cycle, then 16 IDLE cycles
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.pkt_abort !== 1'b1 && n < 100);
    chk("t4_abort_delay", n, 32'd28);
    chk("t4_abort_lock", {31'b0, bus.lock_active}, 32'd0);
    chk("t4_abort_ready", {28'b0, bus.req_ready}, 32'b0100);
    @(negedge clk);
    chk("t4_abort_width", {31'b0, bus.pkt_abort}, 32'd0);
    chk("t4_next_start", {31'b0, bus.tx_start}, 32'd1);
    drain();

    // 5: five back-to-back bytes through the transmitter model
    do_reset();
    n = start_cnt;
    push(1, 8'hC1, 1'b0); push(1, 8'h5A, 1'b0); push(1, 8'h00, 1'b0);
    push(1, 8'hFF, 1'b0); push(1, 8'h81, 1'b1);
    drain();
    chk("t5_start_count", start_cnt - n, 32'd5);

    // 6: reset during WAIT_DONE
    do_reset();
    push(3, 8'h66, 1'b0);
    wait_start("t6_start");
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_tx_start", {31'b0, bus.tx_start}, 32'd0);
    chk("t6_tx_data", {24'b0, bus.tx_data}, 32'd0);
    chk("t6_lock", {31'b0, bus.lock_active}, 32'd0);
    chk("t6_grant", {30'b0, bus.grant_id}, 32'd0);
    chk("t6_ready", {28'b0, bus.req_ready}, 32'd0);
    push(0, 8'h77, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_start("t6_restart");
    chk("t6_busy_at_restart", {31'b0, m_busy}, 32'd0);
    drain();

    chk("exp_q_empty", exp_q.size(), 32'd0);
    chk("exp_txd_empty", exp_txd.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
